// File: rtl/rf_scan_ctrl.sv
// rf_scan_ctrl: sequencer for the register/memory debug read port.
//
// On an accepted start it walks `count` consecutive addresses beginning at
// `base_addr`. It issues one read per word, waits out the read-port latency,
// and then presents the word and its address on a valid/ready stream.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   start      begin a scan (sampled only while idle)
//   base_addr  first address, latched on an accepted start
//   count      number of words, latched on an accepted start (0 = empty scan)
//   abort      cancel the scan from any state; wins over every other event
//   rd_addr    address driven to the read port (holds its value outside READ)
//   rd_data    read-port data, valid RD_LAT cycles after rd_addr
//   out_valid  out_data/out_addr hold a word
//   out_ready  consumer accepts the word when out_valid & out_ready
//   out_data   captured word
//   out_addr   address of out_data
//   busy       high whenever a scan is in progress
//   done       one-cycle pulse at scan completion (never during abort or reset)
module rf_scan_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  // The wait counter runs 0..RD_LAT, so READ lasts RD_LAT+1 cycles.
  localparam int unsigned       WaitW    = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [WaitW-1:0]  WaitLast = WaitW'(RD_LAT);
  localparam logic [WaitW-1:0]  WaitOne  = WaitW'(1);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   RemOne   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRead, StHold} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W:0]   rem_q;
  logic [WaitW-1:0]  wait_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      rem_q     <= '0;
      wait_q    <= '0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // A handshake in this cycle is still taken by the consumer; the scan
        // simply ends without advancing and without a done pulse.
        state_q   <= StIdle;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              cur_q <= base_addr;
              rem_q <= count;
              if (count == '0) begin
                done <= 1'b1;
              end else begin
                state_q <= StRead;
                rd_addr <= base_addr;
                wait_q  <= '0;
                busy    <= 1'b1;
              end
            end
          end
          StRead: begin
            if (wait_q == WaitLast) begin
              out_data  <= rd_data;
              out_addr  <= cur_q;
              out_valid <= 1'b1;
              state_q   <= StHold;
            end else begin
              wait_q <= wait_q + WaitOne;
            end
          end
          StHold: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (rem_q == RemOne) begin
                state_q <= StIdle;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                // Address wraps modulo 2^ADDR_W by plain overflow.
                rem_q   <= rem_q - RemOne;
                cur_q   <= cur_q + AddrOne;
                rd_addr <= cur_q + AddrOne;
                wait_q  <= '0;
                state_q <= StRead;
              end
            end
          end
          default: begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
